mf_clken_gen: RTL



---
 rtl/mf_clken_gen.sv | 99 +++++++++
 1 files changed

// File: rtl/mf_clken_gen.sv
// mf_clken_gen: multi-channel fractional clock-enable generator.
// Per-channel phase accumulators emit wrap and quarter-phase pulses.
module mf_clken_gen #(
  parameter int NUM_CH      = 4,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LK_W = $clog2(LOCK_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_incr,
  input  logic [ACC_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] ce_q,
  output logic              locked
);

  // Quarter point and quarter point one full turn later, unwrapped.
  localparam logic [ACC_W:0] QTR =
    {2'b00, 1'b1, {(ACC_W-2){1'b0}}};
  localparam logic [ACC_W:0] WRAP_QTR =
    {2'b10, 1'b1, {(ACC_W-2){1'b0}}};
  localparam logic [LK_W-1:0] LK_MAX =
    LK_W'(LOCK_CYCLES);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] incr;
    logic [ACC_W:0]   sum;
    logic             hit;
    logic             q_cross;
    logic             ce_r;
    logic             ce_q_r;

    // Out-of-range channel numbers never match any channel.
    assign hit = cfg_wr && (cfg_ch == CH_W'(i));
    assign sum = {1'b0, acc} + {1'b0, incr};
    assign q_cross =
      (({1'b0, acc} < QTR) && (sum >= QTR)) ||
      (sum >= WRAP_QTR);

    // Accumulator advance, reload on write, pulses cleared on hold.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        acc    <= '0;
        incr   <= '0;
        ce_r   <= 1'b0;
        ce_q_r <= 1'b0;
      end else if (hit) begin
        acc    <= cfg_phase;
        incr   <= cfg_incr;
        ce_r   <= 1'b0;
        ce_q_r <= 1'b0;
      end else if (run) begin
        acc    <= sum[ACC_W-1:0];
        ce_r   <= sum[ACC_W];
        ce_q_r <= q_cross;
      end else begin
        ce_r   <= 1'b0;
        ce_q_r <= 1'b0;
      end
    end

    assign ce[i]   = ce_r;
    assign ce_q[i] = ce_q_r;
  end

  logic [LK_W-1:0] lk_cnt;
  logic [LK_W-1:0] lk_nxt;
  logic            lk_clr;

  // Any write (even to a missing channel) or a hold restarts settling.
  assign lk_clr = cfg_wr || !run;

  // Saturating settle counter; next value feeds the registered flag.
  always_comb begin
    lk_nxt = lk_cnt;
    if (lk_clr)
      lk_nxt = '0;
    else if (lk_cnt != LK_MAX)
      lk_nxt = lk_cnt + LK_W'(1);
  end

  // Lock counter and registered lock flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_cnt <= '0;
      locked <= 1'b0;
    end else begin
      lk_cnt <= lk_nxt;
      locked <= (lk_nxt == LK_MAX);
    end
  end

endmodule
